// File: rtl/tone_meter_if.sv
// Bus bundle for tone_meter: measurement controls in, measurement results out.
// valid is a one-cycle strobe with no back-pressure (there is no ready): the
// results are latched alongside it and stay stable until the next strobe, so
// a consumer may sample them at the strobe or at any cycle afterwards.
interface tone_meter_if;
  logic [15:0] ticks_per_milli;
  logic        ena;
  logic        sound;
  logic [9:0]  freq;
  logic        ovf;
  logic        valid;
  logic        silent;
  logic        tone_hit;
  logic [1:0]  tone_id;

  // Source of controls and the audio line; consumer of results.
  modport master (
    output ticks_per_milli, ena, sound,
    input  freq, ovf, valid, silent, tone_hit, tone_id
  );

  // The meter itself.
  modport slave (
    input  ticks_per_milli, ena, sound,
    output freq, ovf, valid, silent, tone_hit, tone_id
  );
endinterface

// File: rtl/tone_meter.sv
// Square-wave frequency meter. It counts rising edges of the speaker line
// over a gate of GATE_MS milliseconds, reports the saturated count in 10-bit
// Hz, and classifies the count against the four Simon game tones.
module tone_meter #(
  parameter int GATE_MS = 1000,
  parameter int TOL     = 8
) (
  input  logic         clk,
  input  logic         rst,
  tone_meter_if.slave  bus
);

  localparam int MS_W = (GATE_MS > 1) ? $clog2(GATE_MS) : 1;
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(GATE_MS - 1);
  localparam logic [10:0] CNT_MAX = 11'd2047;

  // Nominal game tones in Hz, indexed by tone_id.
  localparam int TONE [4] = '{196, 262, 330, 784};

  // Synchroniser (s1, s2) and edge-detect history (s3).
  logic s1, s2, s3;
  logic rise;

  // Gate timing.
  logic [15:0]     tick;
  logic [MS_W-1:0] ms;
  logic [15:0]     tpm_last;
  logic            tick_wrap;
  logic            ms_wrap;
  logic            run_q;
  logic            window_end;

  // Edge counting and result computation.
  logic [10:0] count;
  logic [11:0] final_count;
  logic [9:0]  freq_next;
  logic        ovf_next;
  logic        hit_next;
  logic [1:0]  id_next;

  // Registered results.
  logic [9:0] freq_q;
  logic       ovf_q;
  logic       valid_q;
  logic       silent_q;
  logic       hit_q;
  logic [1:0] id_q;

  // Bring the asynchronous audio line into the clock domain and keep one
  // extra stage of history so a rising edge shows up as a single-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.sound;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // A zero ticks_per_milli is read as one. The >= compare lets the tick
  // counter recover at once if the divisor is lowered mid-window.
  assign tpm_last  = (bus.ticks_per_milli == 16'd0) ? 16'd0 : (bus.ticks_per_milli - 16'd1);
  assign tick_wrap = (tick >= tpm_last);
  assign ms_wrap   = (ms >= MS_LAST);

  // run_q remembers that the counters were live last cycle, so a window whose
  // final cycle coincides with ena falling still completes and reports.
  assign window_end = (bus.ena | run_q) & tick_wrap & ms_wrap;

  // Track whether the gate counters were running in the previous cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= 1'b0;
    end else begin
      run_q <= bus.ena;
    end
  end

  // Tick and millisecond counters; both park at zero while disabled so that
  // re-enabling always starts a fresh, full-length window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick <= '0;
      ms   <= '0;
    end else if (!bus.ena) begin
      tick <= '0;
      ms   <= '0;
    end else if (tick_wrap) begin
      tick <= '0;
      ms   <= ms_wrap ? '0 : (ms + 1'b1);
    end else begin
      tick <= tick + 16'd1;
    end
  end

  // Saturating rising-edge counter for the current window. A rise in the
  // window-end cycle belongs to the closing window and is folded into
  // final_count instead of this register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!bus.ena || window_end) begin
      count <= '0;
    end else if (rise && (count != CNT_MAX)) begin
      count <= count + 11'd1;
    end
  end

  assign final_count = {1'b0, count} + {11'd0, rise};
  assign ovf_next    = (final_count > 12'd1023);
  assign freq_next   = ovf_next ? 10'd1023 : final_count[9:0];

  // Match the saturated reading against each nominal tone. Tones sit more
  // than 2*TOL apart, so at most one can match; an overflowed reading never
  // counts as a hit even though it saturates to a fixed value.
  always_comb begin
    hit_next = 1'b0;
    id_next  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if ((int'(freq_next) >= TONE[k] - TOL) &&
          (int'(freq_next) <= TONE[k] + TOL) && !ovf_next) begin
        hit_next = 1'b1;
        id_next  = 2'(k);
      end
    end
  end

  // Latch all results together with a single-cycle valid strobe at the close
  // of each window; otherwise results hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      freq_q   <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      silent_q <= 1'b0;
      hit_q    <= 1'b0;
      id_q     <= 2'd0;
    end else if (window_end) begin
      freq_q   <= freq_next;
      ovf_q    <= ovf_next;
      valid_q  <= 1'b1;
      silent_q <= (final_count == 12'd0);
      hit_q    <= hit_next;
      id_q     <= id_next;
    end else begin
      valid_q  <= 1'b0;
    end
  end

  assign bus.freq     = freq_q;
  assign bus.ovf      = ovf_q;
  assign bus.valid    = valid_q;
  assign bus.silent   = silent_q;
  assign bus.tone_hit = hit_q;
  assign bus.tone_id  = id_q;

endmodule

// File: tb/tb_tone_meter.sv
// Directed bench for tone_meter with ticks_per_milli = 10 and GATE_MS = 1000
// (10000-cycle windows). Exact edge counts are placed inside each window and
// the reported results are compared against hand-computed values.
module tb_tone_meter;

  logic clk = 1'b0;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;
  int valid_seen  = 0;
  logic [9:0] exp_q[$];

  // Clock and reset.
  always #5 clk = ~clk;

  tone_meter_if bus ();

  tone_meter #(.GATE_MS(1000), .TOL(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive len cycles of the audio line starting at the current cycle:
  // n rising edges, one every p cycles from cycle 0, roughly half duty.
  // hold keeps the line high after the last rise; with n == 0 hold means
  // high for the whole span except a falling edge in its final cycle.
  // Counts valid strobes seen in cycles 1..len-1.
  task automatic drive(input int n, input int p, input int len, input bit hold);
    valid_seen = 0;
    for (int c = 0; c < len; c++) begin
      if (c > 0 && bus.valid === 1'b1) valid_seen++;
      if (n == 0) bus.sound = hold && (c < len - 1);
      else if (hold && c >= (n - 1) * p) bus.sound = 1'b1;
      else bus.sound = (c < n * p) && ((c % p) < (p / 2));
      step();
    end
  endtask

  // One complete window from the current cycle, then check the strobe lands
  // exactly len cycles later and the latched results.
  task automatic window(input string tag, input int n, input int p, input int len,
                        input bit hold, input int e_freq, input int e_ovf,
                        input int e_silent, input int e_hit, input int e_id);
    exp_q.push_back(10'(e_freq));
    drive(n, p, len, hold);
    check({tag, ".early_valid"}, 16'(valid_seen), 16'd0);
    check({tag, ".valid"},       16'(bus.valid),  16'd1);
    check({tag, ".freq"},        16'(bus.freq),   16'(exp_q.pop_front()));
    check({tag, ".ovf"},         16'(bus.ovf),    16'(e_ovf));
    check({tag, ".silent"},      16'(bus.silent), 16'(e_silent));
    check({tag, ".tone_hit"},    16'(bus.tone_hit), 16'(e_hit));
    check({tag, ".tone_id"},     16'(bus.tone_id),  16'(e_id));
  endtask

  initial begin
    rst                 = 1'b0;
    bus.ena             = 1'b1;
    bus.ticks_per_milli = 16'd10;
    bus.sound           = 1'b0;
    step();
    step();
    step();
    check("reset.freq",     16'(bus.freq),     16'd0);
    check("reset.ovf",      16'(bus.ovf),      16'd0);
    check("reset.valid",    16'(bus.valid),    16'd0);
    check("reset.silent",   16'(bus.silent),   16'd0);
    check("reset.tone_hit", 16'(bus.tone_hit), 16'd0);
    check("reset.tone_id",  16'(bus.tone_id),  16'd0);

    // Release: the first window starts in this cycle.
    rst = 1'b1;
    window("w322", 322, 31, 10000, 1'b0, 322, 0, 0, 1, 2);
    window("w321", 321, 31, 10000, 1'b0, 321, 0, 0, 0, 0);
    window("w792", 792, 12, 10000, 1'b0, 792, 0, 0, 1, 3);
    window("w793", 793, 12, 10000, 1'b1, 793, 0, 0, 0, 0);

    // Line held high; zero divisor reads as one, so the window is 1000 cycles.
    bus.ticks_per_milli = 16'd0;
    window("silent", 0, 1, 1000, 1'b1, 0, 0, 1, 0, 0);

    bus.ticks_per_milli = 16'd10;
    window("w1500", 1500, 6, 10000, 1'b0, 1023, 1, 0, 0, 0);

    // Shorter 2000-cycle window keeps the run compact.
    bus.ticks_per_milli = 16'd2;
    window("w196", 196, 10, 2000, 1'b0, 196, 0, 0, 1, 0);

    // Reset 5000 cycles into a window: outputs clear at once, no strobe.
    bus.ticks_per_milli = 16'd10;
    drive(100, 20, 5000, 1'b0);
    check("abort.pre_valid", 16'(valid_seen), 16'd0);
    rst = 1'b0;
    #1;
    check("abort.freq",     16'(bus.freq),     16'd0);
    check("abort.tone_hit", 16'(bus.tone_hit), 16'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort.valid", 16'(bus.valid), 16'd0);
    end
    rst = 1'b1;
    window("w262", 262, 38, 10000, 1'b0, 262, 0, 0, 1, 1);

    // ena low 3000 cycles mid-window with edges present: no strobe, hold.
    drive(0, 1, 500, 1'b0);
    bus.ena = 1'b0;
    drive(100, 20, 3000, 1'b0);
    check("ena_low.valid",   16'(valid_seen),  16'd0);
    check("ena_low.freq",    16'(bus.freq),    16'd262);
    check("ena_low.tone_id", 16'(bus.tone_id), 16'd1);
    bus.ena = 1'b1;
    window("w500", 500, 20, 10000, 1'b0, 500, 0, 0, 0, 0);
    step();
    check("w500.valid_drop", 16'(bus.valid), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
